// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers: state encoding
// and the default bundle widths of the ID/EX, EX/MEM and MEM/WB stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int IDEX_CTRL_W  = 16;
  localparam int IDEX_DATA_W  = 96;
  localparam int EXMEM_CTRL_W = 8;
  localparam int EXMEM_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 4;
  localparam int MEMWB_DATA_W = 69;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear, shared by the performance
// counters of the pipeline.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage with a main register and one skid entry,
// flush support and a saturating bubble counter.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W              = IDEX_CTRL_W,
  parameter int DATA_W              = IDEX_DATA_W,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b1,
  parameter int CNT_W               = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);

  stage_state_e      state, state_next;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire, out_fire;
  logic              load_main_in, load_main_skid, load_skid;

  // Ready depends only on the registered state, breaking the out_ready path.
  assign in_ready  = (state != ST_FULL) & ~rst;
  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_next   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid  = 1'b1;
            state_next = ST_FULL;
          end else if (out_fire) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_next     = ST_ONE;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // Control is always scrubbed on flush so a discarded entry can never
  // trigger side effects; data scrubbing is optional.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_ctrl  <= '0;
      out_data  <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      out_ctrl  <= '0;
      skid_ctrl <= '0;
      if (CLEAR_DATA_ON_FLUSH) begin
        out_data  <= '0;
        skid_data <= '0;
      end
    end else begin
      if (load_main_in) begin
        out_ctrl <= in_ctrl;
        out_data <= in_data;
      end else if (load_main_skid) begin
        out_ctrl <= skid_ctrl;
        out_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  pipe_sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (~out_valid),
    .clr  (cnt_clr),
    .count(bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: two instances (data cleared / data held on flush)
// driven in lockstep and compared against a queue-based reference model.
module tb_pipe_skid_stage;

  localparam int CW = 16;
  localparam int DW = 96;

  logic clk, rst, flush, in_valid, out_ready, cnt_clr;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          a_in_ready, a_out_valid;
  logic [CW-1:0] a_out_ctrl;
  logic [DW-1:0] a_out_data;
  logic [2:0]    a_cnt;

  logic          b_in_ready, b_out_valid;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [15:0]   b_cnt;

  int checks = 0;
  int errors = 0;

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1'b1), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .cnt_clr(cnt_clr), .bubble_cnt(a_cnt)
  );

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1'b0), .CNT_W(16)) dut_nc (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .cnt_clr(cnt_clr), .bubble_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an in-order FIFO of at most two entries plus the last
  // head value, which is what the output registers show when nothing is valid.
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [CW-1:0] m_ctrl;
  logic [DW-1:0] m_data_a, m_data_b;
  int            m_cnt_a, m_cnt_b;

  task automatic modelReset();
    q.delete();
    m_ctrl   = '0;
    m_data_a = '0;
    m_data_b = '0;
    m_cnt_a  = 0;
    m_cnt_b  = 0;
  endtask

  task automatic modelStep(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                           input logic ordy, input logic fl, input logic clr);
    bit   rdy, ov;
    ent_t e;
    rdy = (q.size() < 2);
    ov  = (q.size() > 0);
    if (clr) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (!ov) begin
      if (m_cnt_a < 7)     m_cnt_a++;
      if (m_cnt_b < 65535) m_cnt_b++;
    end
    if (fl) begin
      q.delete();
      m_ctrl   = '0;
      m_data_a = '0;
    end else begin
      if (ov && ordy) void'(q.pop_front());
      if (iv && rdy) begin
        e.c = c;
        e.d = d;
        q.push_back(e);
      end
      if (q.size() > 0) begin
        m_ctrl   = q[0].c;
        m_data_a = q[0].d;
        m_data_b = q[0].d;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid", a_out_valid, q.size() != 0);
    checkOutput("in_ready", a_in_ready, q.size() < 2);
    checkOutput("out_ctrl", a_out_ctrl, m_ctrl);
    checkOutput("out_data", a_out_data, m_data_a);
    checkOutput("bubble_cnt", a_cnt, m_cnt_a[2:0]);
    checkOutput("nc_out_valid", b_out_valid, q.size() != 0);
    checkOutput("nc_in_ready", b_in_ready, q.size() < 2);
    checkOutput("nc_out_ctrl", b_out_ctrl, m_ctrl);
    checkOutput("nc_out_data", b_out_data, m_data_b);
    checkOutput("nc_bubble_cnt", b_cnt, m_cnt_b[15:0]);
  endtask

  // One clock cycle: drive after the falling edge, advance the model on the
  // rising edge, compare on the next falling edge.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic ordy,
                               input logic fl, input logic clr);
    logic [CW-1:0] c;
    c         = 16'hC000 ^ d[15:0];
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    @(posedge clk);
    modelStep(iv, c, d, ordy, fl, clr);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_ctrl = '0; in_data = '0;
    modelReset();
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", a_in_ready, 1'b0);
    checkOutput("reset_out_valid", a_out_valid, 1'b0);
    checkOutput("reset_out_data", a_out_data, 0);
    checkOutput("reset_cnt", a_cnt, 0);
    rst = 1'b0;
    #1 checkAll();

    $display("[TB] stream with out_ready high");
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, DW'(k), 1'b1, 1'b0, 1'b0);
      checkOutput("stream_data", a_out_data, k);
      checkOutput("stream_ready", a_in_ready, 1'b1);
    end
    checkOutput("stream_bubble", a_cnt, 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, DW'(10), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(11), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(12), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(12), 1'b0, 1'b0, 1'b0);
    checkOutput("bp_hold_data", a_out_data, 10);
    checkOutput("bp_in_ready", a_in_ready, 1'b0);
    applyStimulus(1'b1, DW'(12), 1'b1, 1'b0, 1'b0);
    checkOutput("bp_second", a_out_data, 11);
    applyStimulus(1'b1, DW'(12), 1'b1, 1'b0, 1'b0);
    checkOutput("bp_third", a_out_data, 12);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_drained", a_out_valid, 1'b0);

    $display("[TB] flush while full");
    applyStimulus(1'b1, DW'(20), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(21), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(22), 1'b0, 1'b1, 1'b0);
    checkOutput("flush_valid", a_out_valid, 1'b0);
    checkOutput("flush_ctrl", a_out_ctrl, 0);
    checkOutput("flush_data", a_out_data, 0);
    checkOutput("nc_flush_data", b_out_data, 20);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_dropped", a_out_valid, 1'b0);

    $display("[TB] flush with data held");
    applyStimulus(1'b1, DW'(8'h55), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("hold_nc_data", b_out_data, 8'h55);
    checkOutput("hold_nc_ctrl", b_out_ctrl, 0);
    checkOutput("hold_nc_valid", b_out_valid, 1'b0);

    $display("[TB] counter saturation");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("sat_cnt", a_cnt, (i < 7) ? i : 7);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("cnt_clr", a_cnt, 0);

    $display("[TB] asynchronous reset while full");
    applyStimulus(1'b1, DW'(30), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(31), 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid", a_out_valid, 1'b0);
    checkOutput("arst_ctrl", a_out_ctrl, 0);
    checkOutput("arst_data", a_out_data, 0);
    checkOutput("arst_cnt", a_cnt, 0);
    checkOutput("arst_nc_data", b_out_data, 0);
    checkOutput("arst_in_ready", a_in_ready, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    #1 checkAll();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    {$urandom(), $urandom(), $urandom()},
                    $urandom_range(0, 9) < 7,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised elastic pipeline stage register that generalises the fixed ID/EX latch into a reusable valid/ready stage with a two-entry skid buffer. It sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB) and carries a control bundle and a data bundle of configurable width. Flush clears the stage, and backpressure stalls it without loss. A saturating bubble counter supports performance analysis.

## Interface
- CTRL_W, 16, width of control bundle (RegWrite, MemtoReg, ALU control, …); zeroed on flush
- DATA_W, 96, width of data bundle (operands, immediate, register IDs)
- CLEAR_DATA_ON_FLUSH, 1, 1: data also zeroed on flush; 0: data held
- CNT_W, 16, bubble counter width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all held entries (branch mispredict/hazard)
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_ctrl  out  CTRL_W  head control bundle
- out_data  out  DATA_W  head data bundle
- cnt_clr  in  1  synchronous clear of bubble counter
- bubble_cnt  out  CNT_W  cycles with out_valid==0, saturating

## Operation
- The interface is fixed as follows: one clock, clk; reset rst, asynchronous and active-high.
- Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
- Storage: main register (drives out_*) and skid register. The state is held in a 2-bit register: EMPTY, ONE, FULL.
- in_ready = (state != FULL) & !rst. It depends only on state, so no combinational path runs from out_ready to in_ready.
- EMPTY: input fire -> main <= in, go to ONE.
- ONE:
  - input fire with output fire -> main <= in, stay in ONE.
  - input fire without output fire -> skid <= in, go to FULL.
  - output fire only -> go to EMPTY.
- FULL: no input accepted. Output fire -> main <= skid, go to ONE.
- Order is preserved: the skid entry always follows the main entry.
- Flush has priority over every transition:
  - next state is EMPTY.
  - out_ctrl and skid ctrl are zeroed.
  - data is zeroed if CLEAR_DATA_ON_FLUSH = 1, otherwise held.
- A downstream output fire in the flush cycle counts as delivered. An input fire in the flush cycle is dropped.
- out_valid = (state != EMPTY).
- bubble_cnt:
  - increments by 1 each cycle out_valid == 0.
  - saturates at 2^CNT_W-1.
  - cnt_clr has priority and sets it to 0.
  - flush does not clear it.

## Timing
- Reset values: state EMPTY, out_valid 0, out_ctrl 0, out_data 0, skid 0, bubble_cnt 0, in_ready 0 while rst is high and 1 in the first cycle after release.
- Latency: an entry accepted at edge N appears on out_* after edge N (1 cycle).
- Throughput: 1 entry per cycle with out_ready held high. The skid entry is never used in that case.
- A downstream stall of k cycles with continuous input:
  - exactly one extra entry is absorbed.
  - in_ready falls 1 cycle after the stall begins.
  - in_ready rises 1 cycle after out_ready returns.
- out_* must be stable while out_valid & !out_ready, except on flush.
- Reset asserted mid-stream: all entries are lost immediately and asynchronously. No partial entry appears after release.
- Flush with state FULL and no out_ready: both entries are discarded, and out_valid is 0 next cycle.

## Structure
- Package pipe_pkg holds:
  - state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - the default CTRL_W/DATA_W constants for the ID/EX, EX/MEM and MEM/WB bundles.
- Sub-module pipe_sat_counter (parameter W; inputs inc, clr; output count) implements bubble_cnt and is reused by other performance counters.
- Existing stage registers become instances of pipe_skid_stage with the bundles concatenated at the instance.

## Test plan
- Reset then stream: rst pulse, then in_valid=1 with in_data=1,2,3,4 on consecutive cycles and out_ready=1 -> out_data 1,2,3,4 one cycle later each, in_ready constantly 1, bubble_cnt=1.
- Backpressure: stream 10,11,12 with out_ready=0 from cycle 2 for 3 cycles -> state FULL holding 10 (out) and 11 (skid), in_ready=0, 12 held upstream; after out_ready=1 the output reads 10,11,12 in order with none lost or duplicated.
- Flush in FULL: hold 20/21 with out_ready=0, assert flush with in_valid=1 carrying 22 -> next cycle out_valid=0, out_ctrl=0, out_data=0 (CLEAR_DATA_ON_FLUSH=1), 22 dropped.
- Flush with CLEAR_DATA_ON_FLUSH=0: flush while out_data=0x55 -> out_ctrl=0, out_data stays 0x55, out_valid=0.
- Counter saturation with CNT_W=3: idle 10 cycles -> bubble_cnt goes 1..7 then holds 7; cnt_clr for 1 cycle -> 0 next cycle.
- Async reset mid-FULL: assert rst between clock edges -> out_valid, out_ctrl, out_data and bubble_cnt go to 0 immediately without a clock edge.
